// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational RV32I ALU between
// two valid/ready requesters. The winning request's operands are driven to the
// ALU and the result is captured into a single tagged response slot, giving
// one-cycle latency and one operation per cycle when the consumer keeps up.

`ifndef ALU_SHARE_ALUCODES
`define ALU_SHARE_ALUCODES
`define ADD  4'd0
`define SLL  4'd1
`define SLT  4'd2
`define SLTU 4'd3
`define XOR  4'd4
`define SRL  4'd5
`define OR   4'd6
`define AND  4'd7
`define SRA  4'd8
`define SUB  4'd9
`endif

module alu_share_arbiter #(
  parameter int unsigned dataW = 32
) (
  input  logic             clock,
  input  logic             nReset,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [dataW-1:0] req0_A,
  input  logic [dataW-1:0] req0_B,
  input  logic [3:0]       req0_alucode,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [dataW-1:0] req1_A,
  input  logic [dataW-1:0] req1_B,
  input  logic [3:0]       req1_alucode,

  output logic [dataW-1:0] alu_A,
  output logic [dataW-1:0] alu_B,
  output logic [3:0]       alu_code,
  input  logic [dataW-1:0] alu_result,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [dataW-1:0] rsp_result,
  output logic             rsp_err
);

  typedef enum logic [1:0] {
    GntNone = 2'd0,
    Gnt0    = 2'd1,
    Gnt1    = 2'd2
  } gnt_e;

  // Response slot and fairness state
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [dataW-1:0] r_rsp_result;
  logic             r_rsp_err;
  logic             r_last_grant;

  gnt_e             w_gnt;
  logic             w_can_accept;
  logic             w_fire;
  logic             w_fire_id;
  logic             w_illegal;
  logic             w_req0_ready;
  logic             w_req1_ready;

  // Slot can take a new result if empty or being drained this cycle
  assign w_can_accept = !r_rsp_valid || rsp_ready;

  // Round-robin grant; on conflict the requester not served last wins
  always_comb begin
    w_gnt = GntNone;
    if (req0_valid && req1_valid) begin
      w_gnt = r_last_grant ? Gnt0 : Gnt1;
    end else if (req0_valid) begin
      w_gnt = Gnt0;
    end else if (req1_valid) begin
      w_gnt = Gnt1;
    end
  end

  // Ready is gated by reset so nothing is accepted during a reset cycle
  always_comb begin
    w_req0_ready = (w_gnt == Gnt0) && w_can_accept && nReset;
    w_req1_ready = (w_gnt == Gnt1) && w_can_accept && nReset;
  end

  // Operand mux: winner drives the ALU even when stalled; idle drives ADD 0,0
  always_comb begin
    alu_A    = '0;
    alu_B    = '0;
    alu_code = `ADD;
    unique case (w_gnt)
      Gnt0: begin
        alu_A    = req0_A;
        alu_B    = req0_B;
        alu_code = req0_alucode;
      end
      Gnt1: begin
        alu_A    = req1_A;
        alu_B    = req1_B;
        alu_code = req1_alucode;
      end
      default: ;
    endcase
  end

  assign w_fire    = (req0_valid && w_req0_ready) || (req1_valid && w_req1_ready);
  assign w_fire_id = w_req1_ready;
  // Codes above SUB have no ALU meaning; their result is forced to zero
  assign w_illegal = (alu_code > `SUB);

  // Response slot: load on fire, clear on drain, hold otherwise
  always_ff @(posedge clock) begin
    if (!nReset) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_err    <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_fire) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= w_fire_id;
      r_rsp_result <= w_illegal ? '0 : alu_result;
      r_rsp_err    <= w_illegal;
      r_last_grant <= w_fire_id;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign req0_ready = w_req0_ready;
  assign req1_ready = w_req1_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_err    = r_rsp_err;

`ifndef SYNTHESIS
  // Only one requester may be accepted per cycle
  a_one_ready: assert property (@(posedge clock) !(req0_ready && req1_ready));
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed testbench for alu_share_arbiter with a behavioural RV32I ALU model
// hanging off the shared ALU port.
module tb_alu_share_arbiter;

  localparam logic [3:0] CAdd = 4'd0;
  localparam logic [3:0] CSll = 4'd1;
  localparam logic [3:0] CSub = 4'd9;

  logic        clock;
  logic        nReset;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_A, req0_B;
  logic [3:0]  req0_alucode;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_A, req1_B;
  logic [3:0]  req1_alucode;
  logic [31:0] alu_A, alu_B, alu_result;
  logic [3:0]  alu_code;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_result;

  int n_checks = 0;
  int n_errors = 0;

  alu_share_arbiter #(.dataW(32)) dut (
    .clock        (clock),
    .nReset       (nReset),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_A       (req0_A),
    .req0_B       (req0_B),
    .req0_alucode (req0_alucode),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_A       (req1_A),
    .req1_B       (req1_B),
    .req1_alucode (req1_alucode),
    .alu_A        (alu_A),
    .alu_B        (alu_B),
    .alu_code     (alu_code),
    .alu_result   (alu_result),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_err      (rsp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // External shared ALU; illegal codes return junk so zeroing is observable
  always_comb begin
    alu_result = 32'hDEAD_BEEF;
    case (alu_code)
      4'd0: alu_result = alu_A + alu_B;
      4'd1: alu_result = alu_A << alu_B[4:0];
      4'd2: alu_result = {31'b0, $signed(alu_A) < $signed(alu_B)};
      4'd3: alu_result = {31'b0, alu_A < alu_B};
      4'd4: alu_result = alu_A ^ alu_B;
      4'd5: alu_result = alu_A >> alu_B[4:0];
      4'd6: alu_result = alu_A | alu_B;
      4'd7: alu_result = alu_A & alu_B;
      4'd8: alu_result = $signed(alu_A) >>> alu_B[4:0];
      4'd9: alu_result = alu_A - alu_B;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b);
    req0_valid = v; req0_alucode = c; req0_A = a; req0_B = b;
  endtask

  task automatic set_req1(input logic v, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b);
    req1_valid = v; req1_alucode = c; req1_A = a; req1_B = b;
  endtask

  initial begin
    nReset = 1'b0;
    rsp_ready = 1'b0;
    set_req0(1'b1, CAdd, 32'd1, 32'd2);
    set_req1(1'b1, CAdd, 32'd3, 32'd4);
    #1;
    check("reset_rdy0", {31'b0, req0_ready}, 32'd0);
    check("reset_rdy1", {31'b0, req1_ready}, 32'd0);
    tick();
    tick();
    check("reset_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_id", {31'b0, rsp_id}, 32'd0);
    check("reset_result", rsp_result, 32'd0);
    check("reset_err", {31'b0, rsp_err}, 32'd0);

    // Idle: ALU driven with ADD 0,0 and nothing is accepted
    nReset = 1'b1;
    set_req0(1'b0, CSub, 32'd9, 32'd9);
    set_req1(1'b0, CSub, 32'd9, 32'd9);
    rsp_ready = 1'b1;
    #1;
    check("idle_alu_A", alu_A, 32'd0);
    check("idle_alu_B", alu_B, 32'd0);
    check("idle_alu_code", {28'b0, alu_code}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_valid", {31'b0, rsp_valid}, 32'd0);
    end

    // Single op: 5 + 7 from req0, response the next cycle, drained after
    set_req0(1'b1, CAdd, 32'd5, 32'd7);
    #1;
    check("single_rdy0", {31'b0, req0_ready}, 32'd1);
    check("single_alu_A", alu_A, 32'd5);
    tick();
    set_req0(1'b0, CAdd, 32'd0, 32'd0);
    check("single_valid", {31'b0, rsp_valid}, 32'd1);
    check("single_id", {31'b0, rsp_id}, 32'd0);
    check("single_result", rsp_result, 32'd12);
    check("single_err", {31'b0, rsp_err}, 32'd0);
    tick();
    check("single_drain", {31'b0, rsp_valid}, 32'd0);

    // Conflict: req0 was served last, so req1 wins first, then alternate
    set_req0(1'b1, CSub, 32'd10, 32'd3);
    set_req1(1'b1, CSll, 32'd1, 32'd4);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_rdy0", {31'b0, req0_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      check("rr_rdy1", {31'b0, req1_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      tick();
      check("rr_valid", {31'b0, rsp_valid}, 32'd1);
      check("rr_id", {31'b0, rsp_id}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_result", rsp_result, (i % 2 == 0) ? 32'd16 : 32'd7);
    end
    set_req0(1'b0, CAdd, 32'd0, 32'd0);
    set_req1(1'b0, CAdd, 32'd0, 32'd0);
    tick();
    check("rr_drain", {31'b0, rsp_valid}, 32'd0);

    // Backpressure: hold 12 while req1 (20 + 22) waits
    set_req0(1'b1, CAdd, 32'd5, 32'd7);
    rsp_ready = 1'b0;
    tick();
    set_req0(1'b0, CAdd, 32'd0, 32'd0);
    set_req1(1'b1, CAdd, 32'd20, 32'd22);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_rdy1", {31'b0, req1_ready}, 32'd0);
      check("bp_alu_A", alu_A, 32'd20);
      tick();
      check("bp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_result", rsp_result, 32'd12);
      check("bp_id", {31'b0, rsp_id}, 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_rdy1", {31'b0, req1_ready}, 32'd1);
    tick();
    set_req1(1'b0, CAdd, 32'd0, 32'd0);
    check("bp_next_valid", {31'b0, rsp_valid}, 32'd1);
    check("bp_next_id", {31'b0, rsp_id}, 32'd1);
    check("bp_next_result", rsp_result, 32'd42);

    // Illegal code: result forced to zero, error flagged
    set_req1(1'b1, 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    set_req1(1'b0, CAdd, 32'd0, 32'd0);
    check("ill_valid", {31'b0, rsp_valid}, 32'd1);
    check("ill_id", {31'b0, rsp_id}, 32'd1);
    check("ill_err", {31'b0, rsp_err}, 32'd1);
    check("ill_result", rsp_result, 32'd0);
    tick();
    check("ill_drain_valid", {31'b0, rsp_valid}, 32'd0);
    check("ill_drain_id_hold", {31'b0, rsp_id}, 32'd1);
    check("ill_drain_err_hold", {31'b0, rsp_err}, 32'd1);

    // Reset mid-stall: req0 served last, yet after reset req0 must win again
    set_req0(1'b1, CAdd, 32'd5, 32'd7);
    rsp_ready = 1'b0;
    tick();
    check("stall_valid", {31'b0, rsp_valid}, 32'd1);
    set_req1(1'b1, CSll, 32'd1, 32'd4);
    nReset = 1'b0;
    #1;
    check("rst_stall_rdy0", {31'b0, req0_ready}, 32'd0);
    check("rst_stall_rdy1", {31'b0, req1_ready}, 32'd0);
    tick();
    check("rst_stall_valid", {31'b0, rsp_valid}, 32'd0);
    nReset = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("post_rst_rdy0", {31'b0, req0_ready}, 32'd1);
    check("post_rst_rdy1", {31'b0, req1_ready}, 32'd0);
    tick();
    set_req0(1'b0, CAdd, 32'd0, 32'd0);
    set_req1(1'b0, CAdd, 32'd0, 32'd0);
    check("post_rst_id", {31'b0, rsp_id}, 32'd0);
    check("post_rst_result", rsp_result, 32'd12);

    // Idle again: slot drains and stays empty
    #1;
    check("end_alu_code", {28'b0, alu_code}, 32'd0);
    check("end_alu_B", alu_B, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("end_idle_valid", {31'b0, rsp_valid}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
